// File: rtl/rv32_pkg.sv
// Shared RV32i fetch types: instruction constants, fetch FSM states, buffer entry.
package rv32_pkg;

    localparam logic [31:0] RV_NOP      = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        ERR    = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, instr} buffer between fetch and decode, with single-cycle flush.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t          mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush_i)
            count_d = '0;
        else if (push_i && !pop_i)
            count_d = count_q + 1'b1;
        else if (!push_i && pop_i)
            count_d = count_q - 1'b1;
    end

    // Storage and pointers; flush drops every entry, including one popped this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_i) begin
                    mem_q[wr_ptr_q] <= wdata_i;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, feeds decode through a small buffer,
// and handles redirects, halting and misaligned redirect targets.
module fetch_ctrl
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_e  state_q;
    logic [31:0]   pc_q;
    logic          misalign_q;

    logic [CW-1:0] count;
    logic          buf_empty, buf_full;
    logic          redir_act, redir_bad, push, pop;
    fetch_entry_t  wr_entry, head;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == CW'(DEPTH));

    // Redirects are dead once in ERR; a target with low bits set is fatal.
    assign redir_act = redirect_valid && (state_q != ERR);
    assign redir_bad = redir_act && (redirect_pc[1:0] != 2'b00);

    assign pop  = out_valid && out_ready;
    assign push = (state_q == FETCH) && !halt_req && !redirect_valid &&
                  (!buf_full || pop);

    assign wr_entry = '{pc: pc_q, instr: imem_instr};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redir_act),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count)
    );

    // FSM, pc and sticky error; redirect outranks halt and a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            if (redir_bad) begin
                state_q    <= ERR;
                misalign_q <= 1'b1;
            end else if (redir_act) begin
                pc_q <= redirect_pc;
                if (state_q == HALTED && !halt_req) state_q <= FETCH;
            end else begin
                if (push) pc_q <= pc_q + 32'(INSTR_BYTES);
                case (state_q)
                    FETCH:   if (halt_req)  state_q <= HALTED;
                    HALTED:  if (!halt_req) state_q <= FETCH;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = !buf_empty && (state_q != ERR);
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign misalign_err = misalign_q;
    assign busy         = (state_q == FETCH) || !buf_empty;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, backpressure, redirects, misalign, wrap, halt.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_instr, redirect_pc;
    logic        redirect_valid = 1'b0, halt_req = 1'b0, out_ready = 1'b1;
    logic        out_valid, misalign_err, busy;
    logic [31:0] out_instr, out_pc;

    logic [31:0] imem_addr2, imem_instr2, out_instr2, out_pc2;
    logic        out_valid2, misalign_err2, busy2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory word k = NOP + (k << 20)
    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'h0000_0013 + ((a >> 2) << 20);
    endfunction

    assign imem_instr  = memw(imem_addr);
    assign imem_instr2 = memw(imem_addr2);

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .misalign_err(misalign_err), .busy(busy)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .halt_req(1'b0),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2),
        .misalign_err(misalign_err2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        redirect_pc = 32'h0;
        #2;
        // reset values
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_addr", imem_addr, 32'h0);

        // 1: streaming, out_ready=1; wrap DUT runs alongside
        out_ready = 1'b1;
        do_reset();
        chk("t1_lat", {31'b0, out_valid}, 32'd0);
        tick();
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_in0", out_instr, 32'h0000_0013);
        chk("t5_pc0", out_pc2, 32'hFFFF_FFF8);
        chk("t5_in0", out_instr2, 32'hFFE0_0013);
        tick();
        chk("t1_pc1", out_pc, 32'h4);
        chk("t1_in1", out_instr, 32'h0010_0013);
        chk("t5_pc1", out_pc2, 32'hFFFF_FFFC);
        chk("t5_in1", out_instr2, 32'hFFF0_0013);
        tick();
        chk("t1_pc2", out_pc, 32'h8);
        chk("t1_in2", out_instr, 32'h0020_0013);
        chk("t5_pc2", out_pc2, 32'h0);
        chk("t5_in2", out_instr2, 32'h0000_0013);
        tick();
        chk("t1_pc3", out_pc, 32'hC);
        chk("t1_v3", {31'b0, out_valid}, 32'd1);

        // 2: backpressure
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_pc", out_pc, 32'h0);
        end
        chk("t2_addr", imem_addr, 32'h8);
        chk("t2_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t2_pc4", out_pc, 32'h4);
        tick();
        chk("t2_pc8", out_pc, 32'h8);
        chk("t2_in8", out_instr, 32'h0020_0013);

        // 3: aligned redirect while buffer holds 0 and 4
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        #1;
        chk("t3_head0", out_pc, 32'h0);
        chk("t3_acc", {31'b0, out_valid}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        chk("t3_flush", {31'b0, out_valid}, 32'd0);
        chk("t3_addr", imem_addr, 32'h40);
        tick();
        chk("t3_pc40", out_pc, 32'h40);
        chk("t3_in40", out_instr, 32'h0100_0013);
        chk("t3_v", {31'b0, out_valid}, 32'd1);

        // 4: misaligned redirect
        out_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        tick();
        redirect_valid = 1'b0;
        chk("t4_mis", {31'b0, misalign_err}, 32'd1);
        chk("t4_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_addr", imem_addr, 32'h8);
        tick();
        tick();
        tick();
        chk("t4_valid_late", {31'b0, out_valid}, 32'd0);
        chk("t4_busy", {31'b0, busy}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t4_ign_addr", imem_addr, 32'h8);
        chk("t4_ign_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_sticky", {31'b0, misalign_err}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_mis", {31'b0, misalign_err}, 32'd0);
        chk("t4_rst_addr", imem_addr, 32'h0);

        // 6: halt with full buffer
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        chk("t6_addr_h", imem_addr, 32'h8);
        out_ready = 1'b1;
        tick();
        chk("t6_drain4", out_pc, 32'h4);
        tick();
        chk("t6_empty", {31'b0, out_valid}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_addr_e", imem_addr, 32'h8);
        halt_req = 1'b0;
        tick();
        chk("t6_busy_up", {31'b0, busy}, 32'd1);
        tick();
        chk("t6_res_v", {31'b0, out_valid}, 32'd1);
        chk("t6_res_pc", out_pc, 32'h8);
        chk("t6_addr_r", imem_addr, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the RV32i core. It owns the program counter and drives the address of the combinational instruction memory (instr_mem: pc in, instr out, same cycle). It captures {pc, instr} pairs into a small in-order buffer and presents them to decode through a valid/ready handshake. It also handles branch/jump redirects, fetch halting and misaligned-target detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned).
DEPTH, 2, fetch buffer entries (power of two, 2..8).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
imem_addr  output  32  address to instr_mem; always equals the internal pc.
imem_instr  input  32  instr_mem read data, valid in the same cycle as imem_addr.
redirect_valid  input  1  one-cycle pulse: flush and restart at redirect_pc.
redirect_pc  input  32  new fetch target.
halt_req  input  1  level; while high, no new fetches are issued.
out_valid  output  1  buffer head holds a valid instruction.
out_ready  input  1  decode accepts the head.
out_instr  output  32  head instruction.
out_pc  output  32  head instruction's address.
misalign_err  output  1  sticky; a redirect target had pc[1:0] != 0.
busy  output  1  high when state is FETCH, or the buffer is non-empty.

Behaviour:
- Reset (async assert, sync release): pc = RESET_PC, buffer empty, state FETCH. Outputs reset to out_valid=0, out_instr=0, out_pc=0, misalign_err=0, busy=1.
- FSM states:
  - FETCH: normal operation.
  - HALTED: entered when halt_req=1 and there is no redirect; returns to FETCH when halt_req=0.
  - ERR: entered on a misaligned redirect; exits only on rst.
- Push rule: a push occurs when state=FETCH, halt_req=0, no redirect, and (count<DEPTH or a pop happens the same cycle). A push stores {pc, imem_instr} at the buffer tail and updates pc <= pc+4.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Pop rule: a pop occurs when out_valid && out_ready. out_instr and out_pc always show the head entry and hold stable while out_valid=1 and out_ready=0.
- Latency: an instruction pushed at edge N has out_valid=1 after edge N. With out_ready held high, throughput is one instruction per cycle with no bubbles.
- Redirect, aligned: at the edge, pc <= redirect_pc and the buffer is flushed (count=0).
  - A pop completing in the same cycle still counts as accepted.
  - No push occurs that cycle.
  - The first new instruction appears one cycle after the redirect edge.
  - Redirect has priority over halt_req and over a full buffer.
  - A redirect while HALTED loads pc but remains HALTED if halt_req=1.
- Redirect, misaligned (redirect_pc[1:0] != 0):
  - buffer flushed, pc unchanged;
  - misalign_err <= 1, state <= ERR;
  - in ERR, out_valid=0 and no pushes occur;
  - further redirects are ignored.
- Full buffer: pc is held and imem_addr stays stable until space frees. Simultaneous pop and push when full is allowed, and count stays DEPTH.
- Empty buffer: out_valid=0; out_instr/out_pc hold their last values (don't-care to decode).
- Halt: the buffer continues to drain. busy falls once HALTED and the buffer is empty.
- Reset mid-operation clears everything immediately, including in ERR.

Decomposition:
- rv32_pkg: constants RV_NOP = 32'h0000_0013, INSTR_BYTES = 4, the fetch state enum {FETCH, HALTED, ERR}, and a fetch entry struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo(DEPTH): synchronous FIFO with count, push/pop/flush, and an async-reset pointer array.
- fetch_ctrl contains the pc register, the FSM, and the push/pop/redirect priority logic.

Test Plan:
1. Reset, out_ready=1, memory word k = 32'h0000_0013 + (k<<20) → out_pc 0,4,8,C… on consecutive cycles with matching out_instr; the first out_valid comes one cycle after reset release.
2. out_ready=0 for 5 cycles → count saturates at 2, imem_addr frozen at 32'h8, out_pc=0 held stable. Then out_ready=1 → out_pc 0,4,8 with no gaps or duplicates.
3. Redirect to 32'h0000_0040 while the buffer holds 0 and 4 and out_ready=1 → entry 0 accepted, entry 4 discarded, next out_pc=32'h40 two cycles after the pulse.
4. Redirect to 32'h0000_0042 → misalign_err=1 next cycle, out_valid=0 permanently. A later redirect to 32'h80 is ignored; rst clears the error.
5. RESET_PC=32'hFFFF_FFF8, out_ready=1 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. halt_req=1 with a full buffer → no imem_addr change, buffer drains, busy=0. Deassert halt_req → fetch resumes at the held pc.
